// File: rtl/array_18_arb_if.sv
// Requester-side handshake bundle for array_18_arb: two request channels
// and two one-entry read response channels.
interface array_18_arb_if #(
  parameter int ADDR_W = 11,
  parameter int LANES  = 10,
  parameter int DATA_W = 170
);
  logic              r0_req_valid;
  logic              r0_req_ready;
  logic              r0_req_write;
  logic [ADDR_W-1:0] r0_req_addr;
  logic [LANES-1:0]  r0_req_wmask;
  logic [DATA_W-1:0] r0_req_wdata;
  logic              r0_resp_valid;
  logic              r0_resp_ready;
  logic [DATA_W-1:0] r0_resp_data;

  logic              r1_req_valid;
  logic              r1_req_ready;
  logic              r1_req_write;
  logic [ADDR_W-1:0] r1_req_addr;
  logic [LANES-1:0]  r1_req_wmask;
  logic [DATA_W-1:0] r1_req_wdata;
  logic              r1_resp_valid;
  logic              r1_resp_ready;
  logic [DATA_W-1:0] r1_resp_data;

  // Requester view
  modport master (
    output r0_req_valid, r0_req_write, r0_req_addr, r0_req_wmask, r0_req_wdata, r0_resp_ready,
    input  r0_req_ready, r0_resp_valid, r0_resp_data,
    output r1_req_valid, r1_req_write, r1_req_addr, r1_req_wmask, r1_req_wdata, r1_resp_ready,
    input  r1_req_ready, r1_resp_valid, r1_resp_data
  );

  // Arbiter view
  modport slave (
    input  r0_req_valid, r0_req_write, r0_req_addr, r0_req_wmask, r0_req_wdata, r0_resp_ready,
    output r0_req_ready, r0_resp_valid, r0_resp_data,
    input  r1_req_valid, r1_req_write, r1_req_addr, r1_req_wmask, r1_req_wdata, r1_resp_ready,
    output r1_req_ready, r1_resp_valid, r1_resp_data
  );
endinterface

// File: rtl/array_18_arb.sv
// Two-requester round-robin arbiter/sequencer for the 2048x170 single-port
// array macro. Zero-fills the array after reset, then shares the RW port;
// read data returns through a one-entry response buffer per requester.
module array_18_arb #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int LANES  = 10,
  parameter int LANE_W = 17,
  parameter int DATA_W = LANES * LANE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  array_18_arb_if.slave     req_if,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [LANES-1:0]  RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;          // index of last granted requester
  logic [1:0]        inflight_q, inflight_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q [2];
  logic [DATA_W-1:0] resp_data_d [2];

  logic [1:0]        req_valid, req_write, resp_ready;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [LANES-1:0]  req_wmask [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [1:0]        elig, grant;

  assign req_valid    = {req_if.r1_req_valid,  req_if.r0_req_valid};
  assign req_write    = {req_if.r1_req_write,  req_if.r0_req_write};
  assign resp_ready   = {req_if.r1_resp_ready, req_if.r0_resp_ready};
  assign req_addr[0]  = req_if.r0_req_addr;
  assign req_addr[1]  = req_if.r1_req_addr;
  assign req_wmask[0] = req_if.r0_req_wmask;
  assign req_wmask[1] = req_if.r1_req_wmask;
  assign req_wdata[0] = req_if.r0_req_wdata;
  assign req_wdata[1] = req_if.r1_req_wdata;

  assign req_if.r0_req_ready  = grant[0];
  assign req_if.r1_req_ready  = grant[1];
  assign req_if.r0_resp_valid = resp_valid_q[0];
  assign req_if.r1_resp_valid = resp_valid_q[1];
  assign req_if.r0_resp_data  = resp_data_q[0];
  assign req_if.r1_resp_data  = resp_data_q[1];

  assign init_done = (state_q == ST_RUN);

  // Eligibility and round-robin grant; a read needs a free buffer slot
  // (empty or draining this cycle) and no read already in flight.
  always_comb begin
    elig  = '0;
    grant = '0;
    if (state_q == ST_RUN) begin
      elig[0] = req_valid[0] &&
                (req_write[0] || (!inflight_q[0] && (!resp_valid_q[0] || resp_ready[0])));
      elig[1] = req_valid[1] &&
                (req_write[1] || (!inflight_q[1] && (!resp_valid_q[1] || resp_ready[1])));
    end
    grant[0] = elig[0] && (!elig[1] || last_q);
    grant[1] = elig[1] && (!elig[0] || !last_q);
  end

  // FSM next state and macro port drive: zero-fill sweep, then winner pass-through.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    case (state_q)
      ST_INIT: begin
        // Gated by reset_n so the macro sees no enable while reset is held.
        RW0_en    = reset_n;
        RW0_wmode = 1'b1;
        RW0_wmask = '1;
        RW0_addr  = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (grant[0]) begin
          RW0_en    = 1'b1;
          RW0_wmode = req_write[0];
          RW0_addr  = req_addr[0];
          RW0_wmask = req_wmask[0];
          RW0_wdata = req_wdata[0];
        end else if (grant[1]) begin
          RW0_en    = 1'b1;
          RW0_wmode = req_write[1];
          RW0_addr  = req_addr[1];
          RW0_wmask = req_wmask[1];
          RW0_wdata = req_wdata[1];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Pointer, inflight tracking and response buffers.
  always_comb begin
    last_d       = last_q;
    inflight_d   = '0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    if (grant[0])      last_d = 1'b0;
    else if (grant[1]) last_d = 1'b1;
    for (int unsigned n = 0; n < 2; n++) begin
      inflight_d[n] = grant[n] && !req_write[n];
      if (resp_valid_q[n] && resp_ready[n]) resp_valid_d[n] = 1'b0;
      // Macro read data is valid the cycle after issue; fill wins over pop.
      if (inflight_q[n]) begin
        resp_valid_d[n] = 1'b1;
        resp_data_d[n]  = RW0_rdata;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      last_q         <= 1'b1;
      inflight_q     <= '0;
      resp_valid_q   <= '0;
      resp_data_q[0] <= '0;
      resp_data_q[1] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      inflight_q   <= inflight_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_array_18_arb.sv
// Directed bench for array_18_arb with a behavioural model of the array macro.
module tb_array_18_arb;
  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;
  localparam int LANES  = 10;
  localparam int LANE_W = 17;
  localparam int DATA_W = 170;

  localparam logic [DATA_W-1:0] GARBAGE = {10{17'h15A5A}};
  localparam logic [DATA_W-1:0] D1      = {10{17'h0A5C3}};
  localparam logic [DATA_W-1:0] LANE0   = {153'b0, 17'h1FFFF};
  localparam logic [DATA_W-1:0] LANE1   = {136'b0, 17'h1FFFF, 17'h0};
  localparam logic [DATA_W-1:0] ONES    = '1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en, RW0_wmode;
  logic [LANES-1:0]  RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  array_18_arb_if #(.ADDR_W(ADDR_W), .LANES(LANES), .DATA_W(DATA_W)) bus ();

  array_18_arb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_if    (bus.slave),
    .init_done (init_done),
    .RW0_addr  (RW0_addr),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_wmask (RW0_wmask),
    .RW0_wdata (RW0_wdata),
    .RW0_rdata (RW0_rdata)
  );

  // Macro model: masked lane writes, registered read; never-written entries read as garbage.
  logic [DATA_W-1:0] mem [DEPTH];
  bit                written [DEPTH];
  logic [DATA_W-1:0] rdata_q = '0;
  assign RW0_rdata = rdata_q;

  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int l = 0; l < LANES; l++)
          if (RW0_wmask[l]) mem[RW0_addr][l*LANE_W +: LANE_W] <= RW0_wdata[l*LANE_W +: LANE_W];
        written[RW0_addr] <= 1'b1;
      end else begin
        rdata_q <= written[RW0_addr] ? mem[RW0_addr] : GARBAGE;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input bit w, input logic [ADDR_W-1:0] a,
                         input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
    if (n == 0) begin
      bus.r0_req_valid = v; bus.r0_req_write = w; bus.r0_req_addr = a;
      bus.r0_req_wmask = m; bus.r0_req_wdata = d;
    end else begin
      bus.r1_req_valid = v; bus.r1_req_write = w; bus.r1_req_addr = a;
      bus.r1_req_wmask = m; bus.r1_req_wdata = d;
    end
  endtask

  task automatic set_rready(input int n, input bit r);
    if (n == 0) bus.r0_resp_ready = r;
    else        bus.r1_resp_ready = r;
  endtask

  function automatic logic get_ready(input int n);
    return (n == 0) ? bus.r0_req_ready : bus.r1_req_ready;
  endfunction

  function automatic logic get_rvalid(input int n);
    return (n == 0) ? bus.r0_resp_valid : bus.r1_resp_valid;
  endfunction

  function automatic logic [DATA_W-1:0] get_rdata(input int n);
    return (n == 0) ? bus.r0_resp_data : bus.r1_resp_data;
  endfunction

  // Called at edge+1; returns at edge+1 of the cycle after the grant edge.
  task automatic issue(input int n, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [LANES-1:0] m, input logic [DATA_W-1:0] d, input string nm);
    bit got = 0;
    set_req(n, 1'b1, w, a, m, d);
    for (int k = 0; k < 16 && !got; k++) begin
      #1;
      if (get_ready(n)) got = 1;
      step();
    end
    set_req(n, 1'b0, 1'b0, '0, '0, '0);
    check({"grant_", nm}, DATA_W'(got), DATA_W'(1));
  endtask

  typedef struct {
    int                n;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
    string             name;
  } vec_t;

  vec_t vecs [9];
  int   bad;
  bit   g0 [10], g1 [10], rv0 [10], rv1 [10];
  logic [DATA_W-1:0] rd0 [10], rd1 [10];

  initial begin
    vecs[0] = '{1, 1'b0, 11'h005, 10'h000, '0,   '0,            "rd_init_5"};
    vecs[1] = '{0, 1'b1, 11'h123, 10'h3FF, D1,   '0,            "wr_full"};
    vecs[2] = '{0, 1'b0, 11'h123, 10'h000, '0,   D1,            "rd_full"};
    vecs[3] = '{1, 1'b1, 11'h7FF, 10'h001, ONES, '0,            "wr_lane0"};
    vecs[4] = '{1, 1'b0, 11'h7FF, 10'h000, '0,   LANE0,         "rd_lane0"};
    vecs[5] = '{0, 1'b1, 11'h040, 10'h000, ONES, '0,            "wr_mask0"};
    vecs[6] = '{1, 1'b0, 11'h040, 10'h000, '0,   '0,            "rd_mask0"};
    vecs[7] = '{1, 1'b1, 11'h123, 10'h002, ONES, '0,            "wr_lane1"};
    vecs[8] = '{0, 1'b0, 11'h123, 10'h000, '0,   D1 | LANE1,    "rd_merge"};

    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    set_rready(0, 1'b0);
    set_rready(1, 1'b0);

    // Reset held: no port activity, no ready even with a valid request.
    set_req(0, 1'b1, 1'b1, 11'h001, '1, '0);
    #12;
    check("rst_en", DATA_W'(RW0_en), '0);
    check("rst_ready", DATA_W'(bus.r0_req_ready), '0);
    check("rst_init_done", DATA_W'(init_done), '0);
    check("rst_resp_valid", DATA_W'(bus.r0_resp_valid), '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Zero-fill sweep: one write per cycle, addresses 0..DEPTH-1, ready held low.
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && int'(RW0_addr) == i &&
            RW0_wdata === '0 && RW0_wmask === '1 && init_done === 1'b0 &&
            bus.r0_req_ready === 1'b0)) begin
        if (bad == 0) $display("FAIL init_sweep cycle=%0d actual addr=%0d en=%b done=%b required addr=%0d",
                               i, RW0_addr, RW0_en, init_done, i);
        bad++;
      end
      step();
    end
    check("init_sweep_errors", DATA_W'(bad), '0);
    check("init_done_after_sweep", DATA_W'(init_done), DATA_W'(1));
    set_req(0, 1'b0, 1'b0, '0, '0, '0);

    // Table-driven single operations.
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        issue(vecs[i].n, 1'b1, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].name);
      end else begin
        issue(vecs[i].n, 1'b0, vecs[i].addr, '0, '0, vecs[i].name);
        check({vecs[i].name, "_early"}, DATA_W'(get_rvalid(vecs[i].n)), '0);
        step();
        check({vecs[i].name, "_valid"}, DATA_W'(get_rvalid(vecs[i].n)), DATA_W'(1));
        check({vecs[i].name, "_data"}, get_rdata(vecs[i].n), vecs[i].exp);
        set_rready(vecs[i].n, 1'b1);
        step();
        set_rready(vecs[i].n, 1'b0);
        check({vecs[i].name, "_pop"}, DATA_W'(get_rvalid(vecs[i].n)), '0);
      end
    end

    // Both requesters stream reads: grants alternate, starting with r1 (r0 granted last).
    set_rready(0, 1'b1);
    set_rready(1, 1'b1);
    set_req(0, 1'b1, 1'b0, 11'h123, '0, '0);
    set_req(1, 1'b1, 1'b0, 11'h7FF, '0, '0);
    for (int c = 0; c < 10; c++) begin
      #1;
      g0[c] = bus.r0_req_ready; g1[c] = bus.r1_req_ready;
      rv0[c] = bus.r0_resp_valid; rv1[c] = bus.r1_resp_valid;
      rd0[c] = bus.r0_resp_data; rd1[c] = bus.r1_resp_data;
      step();
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    check("alt_first_r1", DATA_W'(g1[0]), DATA_W'(1));
    for (int c = 0; c < 10; c++) begin
      bit e0, e1;
      check($sformatf("alt_one_grant_c%0d", c), DATA_W'(g0[c] ^ g1[c]), DATA_W'(1));
      if (c > 0) check($sformatf("alt_swap_c%0d", c), DATA_W'(g1[c]), DATA_W'(g0[c-1]));
      e0 = (c >= 2) ? g0[c-2] : 1'b0;
      e1 = (c >= 2) ? g1[c-2] : 1'b0;
      check($sformatf("alt_r0_resp_c%0d", c), DATA_W'(rv0[c]), DATA_W'(e0));
      check($sformatf("alt_r1_resp_c%0d", c), DATA_W'(rv1[c]), DATA_W'(e1));
      if (e0) check($sformatf("alt_r0_data_c%0d", c), rd0[c], D1 | LANE1);
      if (e1) check($sformatf("alt_r1_data_c%0d", c), rd1[c], LANE0);
    end
    repeat (4) step();
    check("alt_drained_r0", DATA_W'(bus.r0_resp_valid), '0);
    check("alt_drained_r1", DATA_W'(bus.r1_resp_valid), '0);

    // Backpressure: r1 buffer full and not consumed blocks r1 reads only.
    set_rready(1, 1'b0);
    issue(1, 1'b0, 11'h7FF, '0, '0, "bp_fill");
    step();
    check("bp_full_valid", DATA_W'(bus.r1_resp_valid), DATA_W'(1));
    check("bp_full_data", bus.r1_resp_data, LANE0);
    set_req(0, 1'b1, 1'b0, 11'h123, '0, '0);
    set_req(1, 1'b1, 1'b0, 11'h040, '0, '0);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("bp_r1_blocked_c%0d", c), DATA_W'(bus.r1_req_ready), '0);
      check($sformatf("bp_r0_grant_c%0d", c), DATA_W'(bus.r0_req_ready), DATA_W'(c % 2 == 0));
      check($sformatf("bp_hold_c%0d", c), bus.r1_resp_data, LANE0);
      step();
    end
    set_rready(1, 1'b1);
    #1;
    check("bp_release_grant", DATA_W'(bus.r1_req_ready), DATA_W'(1));
    check("bp_release_r0_lost", DATA_W'(bus.r0_req_ready), '0);
    step();
    set_rready(1, 1'b0);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    check("bp_popped", DATA_W'(bus.r1_resp_valid), '0);
    step();
    check("bp_next_valid", DATA_W'(bus.r1_resp_valid), DATA_W'(1));
    check("bp_next_data", bus.r1_resp_data, '0);
    set_rready(1, 1'b1);
    repeat (3) step();

    // Reset one cycle after an r0 read grant: response dropped, sweep restarts.
    set_rready(0, 1'b0);
    issue(0, 1'b0, 11'h123, '0, '0, "rst_rd");
    reset_n = 1'b0;
    #1;
    check("midrst_en", DATA_W'(RW0_en), '0);
    check("midrst_done", DATA_W'(init_done), '0);
    step();
    check("midrst_no_resp_a", DATA_W'(bus.r0_resp_valid), '0);
    step();
    reset_n = 1'b1;
    #1;
    check("restart_en", DATA_W'(RW0_en), DATA_W'(1));
    check("restart_addr0", DATA_W'(RW0_addr), '0);
    check("restart_wmode", DATA_W'(RW0_wmode), DATA_W'(1));
    step();
    check("restart_addr1", DATA_W'(RW0_addr), DATA_W'(1));
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.r0_resp_valid !== 1'b0) bad++;
      step();
    end
    check("midrst_no_resp_b", DATA_W'(bad), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
